// File: rtl/aho_table_writer.sv
// Aho-Corasick table loader: sweeps every slot to an invalid marker,
// then writes goto/failure entries in arrival order.
module aho_table_writer #(
  parameter int          DEPTH         = 32,
  parameter int          AW            = 5,
  parameter logic [7:0]  INVALID_STATE = 8'hFF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [7:0]    IN_CUR,
  input  logic [3:0]    IN_CHARA,
  input  logic [7:0]    IN_NEXT,
  input  logic [7:0]    IN_FAIL,
  input  logic          IN_LAST,
  output logic          WE,
  output logic [AW-1:0] WADDR,
  output logic [7:0]    WD_CUR,
  output logic [3:0]    WD_CHARA,
  output logic [7:0]    WD_NEXT,
  output logic [7:0]    WD_FAIL,
  output logic [AW:0]   COUNT,
  output logic          BUSY,
  output logic          DONE,
  output logic          TABLE_VALID,
  output logic          ERR_FULL
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LOAD,
    FIN
  } state_t;

  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] clr_cnt;
  logic [AW:0]   count;
  logic          go;
  logic          sweep_we;
  logic          hs;
  logic          ovf;

  assign go       = (state == IDLE) && START;
  assign sweep_we = (state == CLEAR) && (clr_cnt != LAST_ADDR);
  assign IN_READY = (state == LOAD) && (count < FULL);
  assign hs       = IN_VALID && IN_READY;
  assign ovf      = (state == LOAD) && (count == FULL) && IN_VALID;

  assign COUNT = count;
  assign BUSY  = (state != IDLE);
  assign DONE  = (state == FIN);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (START) state_n = CLEAR;
      CLEAR:   if (clr_cnt == LAST_ADDR) state_n = LOAD;
      LOAD:    if ((hs && IN_LAST) || ovf) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Slot 0 is written off the START edge so the sweep ends
  // exactly DEPTH cycles later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WE       <= 1'b0;
      WADDR    <= '0;
      WD_CUR   <= '0;
      WD_CHARA <= '0;
      WD_NEXT  <= '0;
      WD_FAIL  <= '0;
    end else begin
      WE <= 1'b0;
      unique case (1'b1)
        go: begin
          WE       <= 1'b1;
          WADDR    <= '0;
          WD_CUR   <= INVALID_STATE;
          WD_CHARA <= '0;
          WD_NEXT  <= '0;
          WD_FAIL  <= '0;
        end
        sweep_we: begin
          WE       <= 1'b1;
          WADDR    <= clr_cnt + 1'b1;
          WD_CUR   <= INVALID_STATE;
          WD_CHARA <= '0;
          WD_NEXT  <= '0;
          WD_FAIL  <= '0;
        end
        hs: begin
          WE       <= 1'b1;
          WADDR    <= count[AW-1:0];
          WD_CUR   <= IN_CUR;
          WD_CHARA <= IN_CHARA;
          WD_NEXT  <= IN_NEXT;
          WD_FAIL  <= IN_FAIL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clr_cnt     <= '0;
      count       <= '0;
      TABLE_VALID <= 1'b0;
      ERR_FULL    <= 1'b0;
    end else begin
      if (go) begin
        clr_cnt     <= '0;
        count       <= '0;
        TABLE_VALID <= 1'b0;
        ERR_FULL    <= 1'b0;
      end
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (hs) count <= count + 1'b1;
      if (hs && IN_LAST) ERR_FULL <= 1'b0;
      if (ovf) ERR_FULL <= 1'b1;
      if ((state == FIN) && !ERR_FULL) TABLE_VALID <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aho_table_writer.sv
// Bench for aho_table_writer: transaction model of the load sequence
// plus a RAM image compared against the writes the DUT issues.
module tb_aho_table_writer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] IN_CUR = '0;
  logic [3:0] IN_CHARA = '0;
  logic [7:0] IN_NEXT = '0;
  logic [7:0] IN_FAIL = '0;
  logic       IN_LAST = 1'b0;
  logic       WE;
  logic [4:0] WADDR;
  logic [7:0] WD_CUR;
  logic [3:0] WD_CHARA;
  logic [7:0] WD_NEXT;
  logic [7:0] WD_FAIL;
  logic [5:0] COUNT;
  logic       BUSY;
  logic       DONE;
  logic       TABLE_VALID;
  logic       ERR_FULL;

  aho_table_writer dut (
    .CLK(CLK), .RST(RST), .START(START),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_CUR(IN_CUR), .IN_CHARA(IN_CHARA),
    .IN_NEXT(IN_NEXT), .IN_FAIL(IN_FAIL),
    .IN_LAST(IN_LAST), .WE(WE), .WADDR(WADDR),
    .WD_CUR(WD_CUR), .WD_CHARA(WD_CHARA),
    .WD_NEXT(WD_NEXT), .WD_FAIL(WD_FAIL),
    .COUNT(COUNT), .BUSY(BUSY), .DONE(DONE),
    .TABLE_VALID(TABLE_VALID), .ERR_FULL(ERR_FULL)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // model: sweep position (0 = not sweeping), load phase, final cycle
  bit          m_busy, m_fin, m_load, m_err, m_tv;
  int          m_sweep, m_cnt;
  bit          x_we;
  int          x_waddr;
  logic [27:0] x_wd;
  bit          last_hs;
  logic [27:0] exp_ram [32];
  logic [27:0] dut_ram [32];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_fin = 0; m_load = 0; m_err = 0; m_tv = 0;
    m_sweep = 0; m_cnt = 0; x_we = 0; x_waddr = 0; x_wd = '0;
    last_hs = 0;
  endtask

  task automatic compare();
    chk("busy", BUSY, m_busy);
    chk("done", DONE, m_fin);
    chk("in_ready", IN_READY, m_load && m_cnt < 32);
    chk("count", COUNT, m_cnt);
    chk("table_valid", TABLE_VALID, m_tv);
    chk("err_full", ERR_FULL, m_err);
    chk("we", WE, x_we);
    if (x_we) begin
      chk("waddr", WADDR, x_waddr);
      chk("wdata", {WD_CUR, WD_CHARA, WD_NEXT, WD_FAIL}, x_wd);
    end
    if (WE === 1'b1)
      dut_ram[WADDR] = {WD_CUR, WD_CHARA, WD_NEXT, WD_FAIL};
  endtask

  task automatic tick();
    logic [27:0] din;
    bit hs, ovf;
    din = {IN_CUR, IN_CHARA, IN_NEXT, IN_FAIL};
    hs  = m_load && m_cnt < 32 && IN_VALID;
    ovf = m_load && m_cnt == 32 && IN_VALID;
    last_hs = hs;
    x_we = 0;
    if (m_fin) begin
      m_fin = 0; m_busy = 0;
      if (!m_err) m_tv = 1;
    end else if (!m_busy) begin
      if (START) begin
        m_busy = 1; m_tv = 0; m_err = 0; m_cnt = 0;
        x_we = 1; x_waddr = 0; x_wd = {8'hFF, 20'h0};
        exp_ram[0] = x_wd;
        m_sweep = 1;
      end
    end else if (m_sweep > 0) begin
      if (m_sweep < 32) begin
        x_we = 1; x_waddr = m_sweep; x_wd = {8'hFF, 20'h0};
        exp_ram[m_sweep] = x_wd;
        m_sweep++;
      end else begin
        m_sweep = 0; m_load = 1;
      end
    end else if (hs) begin
      x_we = 1; x_waddr = m_cnt; x_wd = din;
      exp_ram[m_cnt] = din;
      m_cnt++;
      if (IN_LAST) begin
        m_load = 0; m_fin = 1; m_err = 0;
      end
    end else if (ovf) begin
      m_err = 1; m_load = 0; m_fin = 1;
    end
    @(posedge CLK);
    #1;
    compare();
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40 && IN_READY !== 1'b1; i++) tick();
    chk("ready_timeout", IN_READY, 1'b1);
  endtask

  task automatic rand_fields();
    IN_CUR = 8'($urandom);
    IN_CHARA = 4'($urandom);
    IN_NEXT = 8'($urandom);
    IN_FAIL = 8'($urandom);
  endtask

  // holds IN_VALID high until the beat is taken; leaves it high
  task automatic send(input bit last);
    int n;
    IN_VALID = 1'b1;
    IN_LAST = last;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_hs && n < 50);
    if (!last_hs) chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #3;
    RST = 1'b0;
    IN_VALID = 1'b0;
    START = 1'b0;
    #1;
    model_reset();
    compare();
    chk("rst_waddr", WADDR, 0);
    chk("rst_wdata", {WD_CUR, WD_CHARA, WD_NEXT, WD_FAIL}, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    int we_cnt, rc, acc, cyc;
    model_reset();
    #12;
    compare();
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // abort a load with reset after three beats
    pulse_start();
    wait_ready();
    for (int b = 0; b < 3; b++) begin
      rand_fields();
      send(1'b0);
    end
    do_reset();
    chk("rst_tv", TABLE_VALID, 0);
    chk("rst_busy", BUSY, 0);
    tick();

    // clear sweep timing
    pulse_start();
    we_cnt = 0;
    rc = 0;
    for (int i = 1; i <= 34; i++) begin
      if (WE === 1'b1) we_cnt++;
      if (IN_READY === 1'b1 && rc == 0) rc = i;
      if (i < 34) tick();
    end
    chk("sweep_we_cycles", we_cnt, 32);
    chk("ready_cycle", rc, 33);
    chk("sweep_slot31", dut_ram[31], 28'hFF0_0000);

    // normal load: 11 back-to-back beats, root entry in slot 1
    for (int b = 0; b < 11; b++) begin
      rand_fields();
      if (b == 1) begin
        IN_CUR = 8'd0; IN_CHARA = 4'd11;
        IN_NEXT = 8'd1; IN_FAIL = 8'd0;
      end
      send(b == 10);
    end
    IN_VALID = 1'b0;
    IN_LAST = 1'b0;
    chk("norm_done", DONE, 1);
    chk("norm_count", COUNT, 11);
    chk("norm_last_addr", WADDR, 10);
    chk("root_slot", dut_ram[1], {8'd0, 4'd11, 8'd1, 8'd0});
    tick();
    chk("norm_tv", TABLE_VALID, 1);
    chk("norm_busy", BUSY, 0);

    // random stalls with START pulses during LOAD
    pulse_start();
    wait_ready();
    acc = 0;
    cyc = 0;
    while (acc < 20 && cyc < 400) begin
      rand_fields();
      IN_VALID = 1'($urandom % 2);
      IN_LAST = (acc == 19);
      START = ($urandom % 6 == 0);
      tick();
      if (last_hs) acc++;
      cyc++;
    end
    START = 1'b0;
    IN_VALID = 1'b0;
    IN_LAST = 1'b0;
    chk("stall_beats", acc, 20);
    tick();
    tick();
    chk("stall_count", COUNT, 20);
    for (int s = 0; s < 32; s++)
      chk($sformatf("readback_%0d", s), dut_ram[s], exp_ram[s]);

    // overflow: 32 beats without IN_LAST, then valid held
    pulse_start();
    wait_ready();
    for (int b = 0; b < 32; b++) begin
      rand_fields();
      send(1'b0);
    end
    tick();
    chk("ovf_ready", IN_READY, 0);
    chk("ovf_done", DONE, 1);
    chk("ovf_err", ERR_FULL, 1);
    IN_VALID = 1'b0;
    tick();
    chk("ovf_tv", TABLE_VALID, 0);
    pulse_start();
    chk("restart_err", ERR_FULL, 0);

    // exact full load
    wait_ready();
    for (int b = 0; b < 32; b++) begin
      rand_fields();
      send(b == 31);
    end
    IN_VALID = 1'b0;
    IN_LAST = 1'b0;
    chk("full_count", COUNT, 32);
    chk("full_err", ERR_FULL, 0);
    tick();
    chk("full_tv", TABLE_VALID, 1);
    for (int s = 0; s < 32; s++)
      chk($sformatf("full_slot_%0d", s), dut_ram[s], exp_ram[s]);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aho_table_writer.md
# aho_table_writer

Loads the Aho-Corasick goto/failure table (current state, character, next state, failure state) into the 32-entry table RAMs that the table reader consumes. It sits between the host or pattern-compiler load stream and the write side of the table RAMs. Each load first sweeps the table to an invalid marker, then writes entries in arrival order under a valid/ready handshake. It flags completion or overflow and tells the reader, through TABLE_VALID, when the table is safe to walk.

## Interface
- DEPTH, 32: number of table entries; must equal the reader's RAM depth.
- AW, 5: address width, log2(DEPTH).
- INVALID_STATE, 8'hFF: marker written into current-state slots during the clear sweep.

Ports:
- CLK  in  1  system clock; all logic rises on posedge CLK.
- RST  in  1  reset, asynchronous, active-low.
- START  in  1  begin a new load; sampled only in IDLE.
- IN_VALID  in  1  entry beat present.
- IN_READY  out  1  writer accepts a beat; high only in LOAD with COUNT < DEPTH.
- IN_CUR  in  8  current (goto source) state.
- IN_CHARA  in  4  input character code.
- IN_NEXT  in  8  goto destination state.
- IN_FAIL  in  8  failure state for this entry's slot.
- IN_LAST  in  1  final entry of this load.
- WE  out  1  table RAM write enable (registered).
- WADDR  out  AW  write address (registered).
- WD_CUR, WD_CHARA, WD_NEXT, WD_FAIL  out  8/4/8/8  write data (registered).
- COUNT  out  AW+1  entries written this load, 0..DEPTH.
- BUSY  out  1  state is not IDLE.
- DONE  out  1  one-cycle pulse when a load terminates.
- TABLE_VALID  out  1  table fully loaded without error.
- ERR_FULL  out  1  sticky overflow flag, cleared by the next START.

## Operation
- The state machine has four states: IDLE, CLEAR, LOAD and FIN.
- IDLE:
  - IN_READY = 0.
  - When START = 1: clear TABLE_VALID and ERR_FULL, set COUNT = 0 and clr_cnt = 0, then go to CLEAR.
- CLEAR:
  - Each cycle registers WE = 1 and WADDR = clr_cnt.
  - Write data is WD_CUR = INVALID_STATE, WD_CHARA = 0, WD_NEXT = 0, WD_FAIL = 0.
  - clr_cnt increments by 1. At clr_cnt = DEPTH-1, go to LOAD.
  - IN_READY = 0 for the whole sweep.
- LOAD:
  - A handshake is IN_VALID & IN_READY at a clock edge.
  - On a handshake, the next cycle has WE = 1, WADDR = COUNT (value before increment), and WD_* equal to the IN_* fields. COUNT increments at that edge.
  - A handshake with IN_LAST = 1 goes to FIN with ERR_FULL = 0.
  - If COUNT = DEPTH and IN_VALID = 1 with no handshake possible: set ERR_FULL = 1 and go to FIN. The beat is dropped and nothing is written.
  - With no handshake, WE = 0.
- FIN (exactly one cycle):
  - DONE = 1.
  - The write of the final entry, if any, is visible this cycle.
  - Next state is IDLE. TABLE_VALID becomes 1 at the same edge if ERR_FULL = 0.
- START outside IDLE is ignored.
- IN_* fields are not range-checked. IN_CHARA is written as given.

## Timing
- Reset (RST = 0, asynchronous) forces:
  - state = IDLE;
  - WE, IN_READY, BUSY, DONE, TABLE_VALID, ERR_FULL = 0;
  - COUNT, WADDR, WD_* = 0;
  - clr_cnt = 0.
- Reset during CLEAR or LOAD aborts the load. RAM contents are then undefined and TABLE_VALID stays 0 until a complete load.
- START sampled at edge k:
  - BUSY = 1 from cycle k+1.
  - WE = 1 for cycles k+1 through k+DEPTH, with WADDR = 0..DEPTH-1.
  - IN_READY = 1 from cycle k+DEPTH+1.
- Write latency is 1 cycle: a beat accepted at edge e appears on WE/WADDR/WD_* in the cycle after e.
- Back-to-back beats are accepted every cycle. With a continuous stream there is no bubble between writes.
- IN_READY depends only on registered state and COUNT, with no combinational path from IN_VALID.
- Last beat accepted at edge e:
  - DONE = 1 and the final WE in cycle e+1;
  - BUSY = 0 and TABLE_VALID = 1 from cycle e+2.
- COUNT holds its value after FIN until the next START.
- IN_LAST on the DEPTH-th beat is a normal completion with ERR_FULL = 0.

## Test plan
- **Reset check:** assert RST = 0 mid-LOAD (after 3 beats), then release → all outputs 0, state IDLE, IN_READY = 0, TABLE_VALID = 0.
- **Clear sweep:** pulse START → 32 consecutive WE cycles, WADDR 0..31, WD_CUR = 8'hFF and other data 0; IN_READY rises in the 33rd cycle after START.
- **Normal load:** 11 beats back-to-back, with the root entry (CUR = 0, CHARA = 11, NEXT = 1, FAIL = 0) at slot 1 and IN_LAST on beat 11.
  - WADDR 0..10 with matching data, each one cycle after its handshake.
  - DONE pulses with the final write; COUNT = 11; TABLE_VALID = 1 the following cycle.
- **Stalls and ignored START:** toggle IN_VALID randomly and pulse START during LOAD.
  - Writes occur only for handshaken beats, in order, with no gaps in WADDR.
  - START is ignored, and the readback of all 32 slots matches the model.
- **Overflow:** send 32 beats with no IN_LAST, then hold IN_VALID = 1.
  - IN_READY = 0 after beat 32; ERR_FULL = 1; DONE pulses; TABLE_VALID stays 0.
  - The next START clears ERR_FULL.
- **Full exact load:** 32 beats with IN_LAST on beat 32 → ERR_FULL = 0, COUNT = 32, TABLE_VALID = 1.
